// File: rtl/regfile_dbg_if.sv
// Command/response bus of the register-file debug port.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1; the source holds valid and its payload
// unchanged until that edge, and ready never depends on the payload.
interface regfile_dbg_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;

  // Command source / response consumer side.
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data
  );

  // Debug block side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data
  );
endinterface

// File: rtl/regfile_dbg.sv
// Debug access block for a 32x32 register file: single-register READ and
// WRITE, DUMP of all 32 registers as a response stream, and CLEAR of
// registers 1..31. Talks to the regfile through one combinational read
// port (rf_ra1/rf_rd1) and one write port (rf_we3/rf_wa3/rf_wd3).
module regfile_dbg (
  input  logic         clk,
  input  logic         reset,
  regfile_dbg_if.slave bus,
  output logic [4:0]   rf_ra1,
  input  logic [31:0]  rf_rd1,
  output logic         rf_we3,
  output logic [4:0]   rf_wa3,
  output logic [31:0]  rf_wd3,
  output logic         busy,
  output logic [2:0]   dbg_state
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [4:0] LAST_REG = 5'd31;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_FETCH   = 3'd1,
    RSP        = 3'd2,
    WR         = 3'd3,
    DUMP_FETCH = 3'd4,
    DUMP_RSP   = 3'd5,
    CLR        = 3'd6
  } state_t;

  state_t      state;
  logic [4:0]  count;      // register index walked by DUMP and CLEAR
  logic [4:0]  addr_q;     // address latched from the accepted command
  logic        rsp_valid_q;
  logic [4:0]  rsp_addr_q;
  logic [31:0] rsp_data_q;
  logic [4:0]  ra1_q;
  logic        we3_q;
  logic [4:0]  wa3_q;
  logic [31:0] wd3_q;

  logic accept;
  logic rsp_fire;

  // Commands are only taken in IDLE; anything offered while busy waits at
  // the source because cmd_ready stays low.
  assign accept   = bus.cmd_valid && (state == IDLE);
  assign rsp_fire = rsp_valid_q && bus.rsp_ready;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_data  = rsp_data_q;

  assign rf_ra1    = ra1_q;
  assign rf_we3    = we3_q;
  assign rf_wa3    = wa3_q;
  assign rf_wd3    = wd3_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Control FSM; every regfile and response output is a register updated
  // on the transition into the state that needs it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= 5'd0;
      addr_q      <= 5'd0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= 5'd0;
      rsp_data_q  <= 32'd0;
      ra1_q       <= 5'd0;
      we3_q       <= 1'b0;
      wa3_q       <= 5'd0;
      wd3_q       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= bus.cmd_addr;
            case (bus.cmd_op)
              OP_READ: begin
                // Present the address so rf_rd1 is valid during RD_FETCH.
                ra1_q <= bus.cmd_addr;
                state <= RD_FETCH;
              end
              OP_WRITE: begin
                // Address 0 is written like any other; the regfile drops it.
                we3_q <= 1'b1;
                wa3_q <= bus.cmd_addr;
                wd3_q <= bus.cmd_data;
                state <= WR;
              end
              OP_DUMP: begin
                count <= 5'd0;
                ra1_q <= 5'd0;
                state <= DUMP_FETCH;
              end
              OP_CLEAR: begin
                // Register 0 is constant, so clearing starts at 1.
                count <= 5'd1;
                we3_q <= 1'b1;
                wa3_q <= 5'd1;
                wd3_q <= 32'd0;
                state <= CLR;
              end
              default: state <= IDLE;
            endcase
          end
        end

        RD_FETCH: begin
          rsp_data_q  <= rf_rd1;
          rsp_addr_q  <= addr_q;
          rsp_valid_q <= 1'b1;
          ra1_q       <= 5'd0;
          state       <= RSP;
        end

        RSP: begin
          // Payload registers are untouched here, so they hold while stalled.
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        WR: begin
          we3_q <= 1'b0;
          wa3_q <= 5'd0;
          wd3_q <= 32'd0;
          state <= IDLE;
        end

        DUMP_FETCH: begin
          rsp_data_q  <= rf_rd1;
          rsp_addr_q  <= count;
          rsp_valid_q <= 1'b1;
          ra1_q       <= 5'd0;
          state       <= DUMP_RSP;
        end

        DUMP_RSP: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
            if (count == LAST_REG) begin
              // Stop at 31 instead of wrapping back to 0.
              count <= 5'd0;
              state <= IDLE;
            end else begin
              count <= count + 5'd1;
              ra1_q <= count + 5'd1;
              state <= DUMP_FETCH;
            end
          end
        end

        CLR: begin
          if (count == LAST_REG) begin
            we3_q <= 1'b0;
            wa3_q <= 5'd0;
            count <= 5'd0;
            state <= IDLE;
          end else begin
            count <= count + 5'd1;
            wa3_q <= count + 5'd1;
          end
        end

        default: begin
          rsp_valid_q <= 1'b0;
          ra1_q       <= 5'd0;
          we3_q       <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dbg.sv
// Bench for regfile_dbg: a behavioural regfile attached to the rf ports,
// a command-level reference model of the register contents, and one task
// per scenario.
module tb_regfile_dbg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rf_ra1;
  logic [31:0] rf_rd1;
  logic        rf_we3;
  logic [4:0]  rf_wa3;
  logic [31:0] rf_wd3;
  logic        busy;
  logic [2:0]  dbg_state;

  regfile_dbg_if bus ();

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference contents: what each register holds according to the commands issued.
  logic [31:0] ref_rf [32];
  // Expected DUMP responses as {addr, data}.
  logic [36:0] exp_q [$];

  // Regfile environment: combinational read, write on clk, register 0 reads 0.
  logic [31:0] rf_mem  [32];
  logic [31:0] rf_seed [32];
  logic        rf_load;

  regfile_dbg dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .rf_ra1    (rf_ra1),
    .rf_rd1    (rf_rd1),
    .rf_we3    (rf_we3),
    .rf_wa3    (rf_wa3),
    .rf_wd3    (rf_wd3),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_rd1 = (rf_ra1 == 5'd0) ? 32'd0 : rf_mem[rf_ra1];

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= rf_seed[i];
    end else if (rf_we3 && (rf_wa3 != 5'd0)) begin
      rf_mem[rf_wa3] <= rf_wd3;
    end
  end

  // ---------------------------------------------------------------- drivers
  // Offer a command and wait until it is taken. Called and returns at posedge+1;
  // acc is the cycle number in which the accept happened.
  task automatic send_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data,
                          output int acc, output bit to);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    to  = 1'b1;
    acc = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin
        acc = cyc;
        to  = 1'b0;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  // Collect one response. mode 0: ready always high; 1: ready toggles while
  // valid, starting low so each response stalls once; 2: random ready.
  task automatic wait_rsp(input int mode, output logic [4:0] a, output logic [31:0] d,
                          output int first, output bit stable, output bit to);
    bit seen;
    bit tog;
    seen = 1'b0; tog = 1'b0; stable = 1'b1; to = 1'b1;
    a = '0; d = '0; first = -1;
    for (int n = 0; n < 300; n++) begin
      if (mode == 0)      bus.rsp_ready = 1'b1;
      else if (mode == 1) bus.rsp_ready = tog;
      else                bus.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        if (!seen) begin
          seen = 1'b1; first = cyc; a = bus.rsp_addr; d = bus.rsp_data;
        end else if (bus.rsp_addr !== a || bus.rsp_data !== d) begin
          stable = 1'b0;
        end
        tog = !tog;
        if (bus.rsp_ready) begin
          to = 1'b0;
          @(posedge clk); #1;
          break;
        end
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] addr, input int mode, output int acc, output int first,
                         output logic [4:0] a, output logic [31:0] d, output bit stable, output bit to);
    bit to_c;
    bit to_r;
    send_cmd(OP_READ, addr, $urandom, acc, to_c);
    wait_rsp(mode, a, d, first, stable, to_r);
    to = to_c | to_r;
  endtask

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data);
    if (addr != 5'd0) ref_rf[addr] = data;
  endtask

  // --------------------------------------------------------------- scenarios
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: cmd_ready=%b busy=%b, want 1/0", bus.cmd_ready, busy);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_addr !== 5'd0 || bus.rsp_data !== 32'd0) begin
      errors++; $display("FAIL reset_rsp: valid=%b addr=%0d data=%h, want 0/0/0",
                         bus.rsp_valid, bus.rsp_addr, bus.rsp_data);
    end
    checks++;
    if (rf_we3 !== 1'b0 || rf_ra1 !== 5'd0) begin
      errors++; $display("FAIL reset_rf: we3=%b ra1=%0d, want 0/0", rf_we3, rf_ra1);
    end
    // A command offered while reset is high must not be taken.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_addr = 5'd3; bus.cmd_data = 32'hA5A5A5A5;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we3 !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_priority: we3=%b busy=%b, want 0/0", rf_we3, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int acc, first; bit to, st; logic [4:0] a; logic [31:0] d;
    send_cmd(OP_WRITE, 5'd5, 32'hDEADBEEF, acc, to);
    model_write(5'd5, 32'hDEADBEEF);
    checks++;
    if (to) begin errors++; $display("FAIL wr5_accept: timed out, want accept"); end
    @(negedge clk);
    checks++;
    if (rf_we3 !== 1'b1 || rf_wa3 !== 5'd5 || rf_wd3 !== 32'hDEADBEEF || busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL wr5_port: we3=%b wa3=%0d wd3=%h busy=%b rdy=%b, want 1/5/deadbeef/1/0",
                         rf_we3, rf_wa3, rf_wd3, busy, bus.cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (rf_we3 !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL wr5_done: we3=%b rdy=%b rsp_valid=%b, want 0/1/0", rf_we3, bus.cmd_ready, bus.rsp_valid);
    end
    @(posedge clk); #1;
    send_cmd(OP_READ, 5'd5, 32'd0, acc, to);
    @(negedge clk);
    checks++;
    if (to || rf_ra1 !== 5'd5 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rd5_fetch: to=%b ra1=%0d rsp_valid=%b, want 0/5/0", to, rf_ra1, bus.rsp_valid);
    end
    @(posedge clk); #1;
    wait_rsp(1, a, d, first, st, to);
    checks++;
    if (to || first != acc + 2) begin
      errors++; $display("FAIL rd5_latency: to=%b first valid cycle %0d, want %0d", to, first, acc + 2);
    end
    checks++;
    if (a !== 5'd5 || d !== ref_rf[5] || !st) begin
      errors++; $display("FAIL rd5_data: addr=%0d data=%h stable=%b, want 5/%h/1", a, d, st, ref_rf[5]);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rd5_after: rsp_valid=%b rdy=%b, want 0/1", bus.rsp_valid, bus.cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_zero();
    int acc, first; bit to, st; logic [4:0] a; logic [31:0] d;
    send_cmd(OP_WRITE, 5'd0, 32'h12345678, acc, to);
    model_write(5'd0, 32'h12345678);
    @(negedge clk);
    checks++;
    if (to || rf_we3 !== 1'b1 || rf_wa3 !== 5'd0 || rf_wd3 !== 32'h12345678) begin
      errors++; $display("FAIL wr0_port: to=%b we3=%b wa3=%0d wd3=%h, want 0/1/0/12345678", to, rf_we3, rf_wa3, rf_wd3);
    end
    @(posedge clk); #1;
    do_read(5'd0, 0, acc, first, a, d, st, to);
    checks++;
    if (to || a !== 5'd0 || d !== ref_rf[0]) begin
      errors++; $display("FAIL rd0_data: to=%b addr=%0d data=%h, want 0/0/%h", to, a, d, ref_rf[0]);
    end
  endtask

  task automatic test_back_to_back();
    int acc_w, acc_r, first; bit to, st; logic [4:0] a, r; logic [31:0] d, wdat;
    r = 5'($urandom_range(1, 31));
    wdat = $urandom;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_addr = r; bus.cmd_data = wdat;
    acc_w = -1;
    for (int n = 0; n < 20 && acc_w < 0; n++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) acc_w = cyc;
      @(posedge clk); #1;
    end
    model_write(r, wdat);
    // Keep cmd_valid high and switch straight to a READ of the same register.
    bus.cmd_op = OP_READ;
    @(negedge clk);
    checks++;
    if (acc_w < 0 || bus.cmd_ready !== 1'b0 || rf_we3 !== 1'b1) begin
      errors++; $display("FAIL b2b_wr_cycle: acc=%0d rdy=%b we3=%b, want accepted/0/1", acc_w, bus.cmd_ready, rf_we3);
    end
    @(posedge clk); #1;
    acc_r = -1;
    for (int n = 0; n < 20 && acc_r < 0; n++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) acc_r = cyc;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (acc_r != acc_w + 2) begin
      errors++; $display("FAIL b2b_accept: read accepted in cycle %0d, want %0d", acc_r, acc_w + 2);
    end
    wait_rsp(0, a, d, first, st, to);
    checks++;
    if (to || a !== r || d !== ref_rf[r]) begin
      errors++; $display("FAIL b2b_data: to=%b addr=%0d data=%h, want 0/%0d/%h", to, a, d, r, ref_rf[r]);
    end
  endtask

  // Run a DUMP and compare up to 'limit' responses against the reference contents.
  task automatic run_dump(input int mode, input int limit);
    int acc, first; bit to, st; logic [4:0] a; logic [31:0] d; logic [36:0] exp;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), ref_rf[i]});
    send_cmd(OP_DUMP, 5'($urandom), $urandom, acc, to);
    checks++;
    if (to) begin errors++; $display("FAIL dump_accept: timed out, want accept"); end
    for (int i = 0; i < limit; i++) begin
      wait_rsp(mode, a, d, first, st, to);
      exp = exp_q.pop_front();
      checks++;
      if (to || !st || {a, d} !== exp) begin
        errors++; $display("FAIL dump_rsp%0d: to=%b stable=%b got %0d/%h, want %0d/%h",
                           i, to, st, a, d, exp[36:32], exp[31:0]);
      end
    end
    if (limit == 32) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL dump_end: busy=%b rdy=%b rsp_valid=%b, want 0/1/0", busy, bus.cmd_ready, bus.rsp_valid);
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
  endtask

  task automatic test_fill_dump();
    int acc; bit to;
    for (int i = 1; i < 32; i++) begin
      send_cmd(OP_WRITE, 5'(i), 32'(i) * 32'h11111111, acc, to);
      model_write(5'(i), 32'(i) * 32'h11111111);
      checks++;
      if (to) begin errors++; $display("FAIL fill_accept%0d: timed out, want accept", i); end
    end
    run_dump(1, 32);
  endtask

  task automatic test_clear();
    int acc; bit to;
    send_cmd(OP_CLEAR, 5'($urandom), $urandom, acc, to);
    checks++;
    if (to) begin errors++; $display("FAIL clr_accept: timed out, want accept"); end
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      checks++;
      if (rf_we3 !== 1'b1 || rf_wa3 !== 5'(k) || rf_wd3 !== 32'd0 || bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL clr_cycle%0d: we3=%b wa3=%0d wd3=%h rsp_valid=%b, want 1/%0d/0/0",
                           k, rf_we3, rf_wa3, rf_wd3, bus.rsp_valid, k);
      end
    end
    @(negedge clk);
    checks++;
    if (rf_we3 !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL clr_end: we3=%b busy=%b, want 0/0", rf_we3, busy);
    end
    @(posedge clk); #1;
    for (int i = 1; i < 32; i++) ref_rf[i] = 32'd0;
    run_dump(2, 32);
  endtask

  task automatic test_random();
    int acc, first; bit to, st; logic [4:0] a, r; logic [31:0] d, w;
    for (int n = 0; n < 40; n++) begin
      r = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        w = $urandom;
        send_cmd(OP_WRITE, r, w, acc, to);
        model_write(r, w);
        checks++;
        if (to) begin errors++; $display("FAIL rnd_wr%0d: timed out, want accept", n); end
      end else begin
        do_read(r, 2, acc, first, a, d, st, to);
        checks++;
        if (to || !st || first != acc + 2 || a !== r || d !== ref_rf[r]) begin
          errors++; $display("FAIL rnd_rd%0d: to=%b stable=%b lat=%0d got %0d/%h, want 2 %0d/%h",
                             n, to, st, first - acc, a, d, r, ref_rf[r]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int acc, first, bad; bit to, st; logic [4:0] a; logic [31:0] d, v10, v11;
    v10 = $urandom | 32'h1; v11 = $urandom | 32'h1;
    send_cmd(OP_WRITE, 5'd10, v10, acc, to); model_write(5'd10, v10);
    send_cmd(OP_WRITE, 5'd11, v11, acc, to); model_write(5'd11, v11);
    send_cmd(OP_CLEAR, 5'd0, 32'd0, acc, to);
    // Registers 1..10 get cleared, then reset lands before register 11.
    for (int k = 1; k <= 10; k++) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) ref_rf[i] = 32'd0;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rf_we3 !== 1'b0 || busy !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clr_abort: %0d cycles with write or busy, want 0", bad); end
    do_read(5'd10, 0, acc, first, a, d, st, to);
    checks++;
    if (to || d !== ref_rf[10]) begin errors++; $display("FAIL clr_abort_r10: data=%h, want %h", d, ref_rf[10]); end
    do_read(5'd11, 0, acc, first, a, d, st, to);
    checks++;
    if (to || d !== ref_rf[11]) begin errors++; $display("FAIL clr_abort_r11: data=%h, want %h", d, ref_rf[11]); end
  endtask

  task automatic test_reset_mid_dump();
    int acc, first, bad; bit to, st; logic [4:0] a; logic [31:0] d, v12;
    v12 = $urandom | 32'h1;
    send_cmd(OP_WRITE, 5'd12, v12, acc, to);
    model_write(5'd12, v12);
    run_dump(0, 10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL dump_reset: rsp_valid=%b rdy=%b busy=%b, want 0/1/0", bus.rsp_valid, bus.cmd_ready, busy);
    end
    bus.rsp_ready = 1'b1;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL dump_reset_extra: %0d cycles with rsp_valid, want 0", bad); end
    do_read(5'd12, 1, acc, first, a, d, st, to);
    checks++;
    if (to || a !== 5'd12 || d !== ref_rf[12]) begin
      errors++; $display("FAIL dump_reset_r12: to=%b addr=%0d data=%h, want 0/12/%h", to, a, d, ref_rf[12]);
    end
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    reset = 1'b1;
    rf_load = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = 5'd0; bus.cmd_data = 32'd0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf_seed[i] = (i == 0) ? 32'd0 : $urandom;
      ref_rf[i]  = rf_seed[i];
    end
    repeat (3) @(posedge clk);
    #1;
    rf_load = 1'b0;
    test_reset();
    test_write_read();
    test_write_zero();
    test_back_to_back();
    test_fill_dump();
    test_clear();
    test_random();
    test_reset_mid_clear();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
